sum_differencer: RTL and testbench
==================================

SUM_DIFFERENCER -- requirements
Module: sum_differencer

Interface
REQ-001 Parameter WIDTH, default 16: data width of in_sum and out.
REQ-002 Parameter DEPTH, fixed at 2: output buffer entries; no other value is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; reset == 0 at a rising clk edge resets the block.
REQ-005 in_sum  input  WIDTH  running sum produced by the accumulator.
REQ-006 in_valid  input  1  in_sum and in_restart are valid this cycle.
REQ-007 in_restart  input  1  the accumulator was cleared before this sample; difference is taken against 0.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 out  output  WIDTH  recovered increment, in_sum minus the previous accepted in_sum, modulo 2^WIDTH.
REQ-010 out_valid  output  1  head buffer entry is valid.
REQ-011 out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 out_first  output  1  head entry was computed against 0: the first sample after reset, or in_restart=1.
REQ-013 out_wrap  output  1  head entry's in_sum was unsigned-less-than the previous sample; the sum wrapped.
REQ-014 sample_count  output  16  number of accepted samples, modulo 2^16.

Function
REQ-015 Accept occurs at a rising edge with in_valid=1, in_ready=1, and reset=1.
REQ-016 Pop occurs at a rising edge with out_valid=1, out_ready=1, and reset=1.
REQ-017 The state machine has two states.
- IDLE: after reset; prev is treated as 0.
- RUN: after the first accept; stays in RUN until reset.
REQ-018 On accept, the block computes diff = (in_sum - base) mod 2^WIDTH.
- base = 0 when in IDLE or in_restart=1; otherwise base = prev.
REQ-019 On accept, the block computes the per-entry flags.
- first = (IDLE or in_restart).
- wrap = (not first) and (in_sum < prev, unsigned).
REQ-020 On accept, prev <= in_sum and the block enters RUN.
REQ-021 On accept, the block pushes {diff, first, wrap} into a 2-entry FIFO whose head drives out, out_first, and out_wrap.
REQ-022 out_valid = (count != 0).
REQ-023 in_ready = (count != 2), derived from registered count only; it has no combinational path from out_ready.
REQ-024 Latency: a sample accepted at edge N into an empty FIFO is presented with out_valid=1 in the cycle after edge N.
REQ-025 With count=1, a simultaneous accept and pop keeps count=1 and the new entry becomes head.
REQ-026 With count=2, in_ready=0 and no accept occurs, even if a pop happens the same edge.
REQ-027 out, out_first, and out_wrap hold stable while out_valid=1 and out_ready=0.
REQ-028 sample_count increments by 1 per accept and wraps from 0xFFFF to 0x0000.
- in_restart does not clear sample_count.
REQ-029 in_restart is ignored when no accept occurs.
REQ-030 When out_valid=0, out, out_first, and out_wrap are 0.

Reset
REQ-031 When reset=0 at an edge, the block takes its reset state on that edge.
- State goes to IDLE, prev to 0, FIFO count to 0, and sample_count to 0.
- The accept and pop of that edge are discarded.
REQ-032 Outputs while reset=0 and in the first cycle after release:
- in_ready is 0 while reset=0 and 1 in the first cycle after release.
- out_valid, out, out_first, and out_wrap are 0.
REQ-033 A reset in mid-operation drops all buffered entries; the next accepted sample has out_first=1.

Verification
REQ-034 Basic run: reset, then sums 18, 27, 31 with out_ready=1.
- Required: out 18 (first=1), 9, 4 (first=0, wrap=0).
- Required: sample_count=3.
REQ-035 Backpressure: out_ready=0, then offer sums 10, 20, 30.
- Required: two accepts, after which in_ready=0 and 30 is held.
- Then set out_ready=1. Required: out 10, 10, 10 in order, and sample_count=3.
REQ-036 Wrap: prev 0xFFF0, then sum 0x0010.
- Required: out=0x0020 and out_wrap=1.
REQ-037 Restart: prev 100, then sum 5 with in_restart=1.
- Required: out=5, out_first=1, out_wrap=0.
- Then sum 8 with in_restart=0. Required: out=3.
REQ-038 Mid-operation reset: two entries buffered and out_ready=0, then reset low for one edge.
- Required: out_valid=0 and in_ready=0 during reset.
- Then sum 7. Required: out=7, out_first=1, sample_count=1.
REQ-039 Simultaneous push and pop at count=1.
- Required: count stays 1 and order is preserved.
- Required: in_ready stays 1 throughout.

Source files
------------

// File: rtl/sum_differencer_if.sv
// Handshake bundle for sum_differencer: running-sum input stream in,
// recovered-increment output stream out, plus the accepted-sample counter.
interface sum_differencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_sum;
  logic             in_valid;
  logic             in_restart;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_wrap;
  logic [15:0]      sample_count;

  modport slave (
    input  in_sum, in_valid, in_restart, out_ready,
    output in_ready, out, out_valid, out_first, out_wrap, sample_count
  );

  modport master (
    output in_sum, in_valid, in_restart, out_ready,
    input  in_ready, out, out_valid, out_first, out_wrap, sample_count
  );
endinterface

// File: rtl/sum_differencer.sv
// Recovers per-sample increments from an accumulator's running sum and
// buffers {diff, first, wrap} in a 2-entry FIFO with a registered in_ready.
module sum_differencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              reset,
  sum_differencer_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             first;
    logic             wrap;
  } entry_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [1:0]       count_q, count_d;
  logic [15:0]      sample_count_q, sample_count_d;
  entry_t           mem_q [2];
  entry_t           mem_d [2];

  logic             accept, pop, full;
  logic [WIDTH-1:0] base;
  entry_t           new_entry;

  // in_ready depends only on registered count, so there is no path from out_ready.
  assign full          = (count_q == 2'(DEPTH));
  assign bus.in_ready  = reset && !full;
  assign bus.out_valid = reset && (count_q != 2'd0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out          = bus.out_valid ? mem_q[0].diff  : '0;
  assign bus.out_first    = bus.out_valid ? mem_q[0].first : 1'b0;
  assign bus.out_wrap     = bus.out_valid ? mem_q[0].wrap  : 1'b0;
  assign bus.sample_count = sample_count_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    count_d        = count_q;
    sample_count_d = sample_count_q;
    mem_d          = mem_q;

    new_entry.first = (state_q == IDLE) || bus.in_restart;
    base            = new_entry.first ? '0 : prev_q;
    new_entry.diff  = bus.in_sum - base;
    new_entry.wrap  = !new_entry.first && (bus.in_sum < prev_q);

    if (accept) begin
      state_d        = RUN;
      prev_d         = bus.in_sum;
      sample_count_d = sample_count_q + 16'd1;
    end

    // Shift-register FIFO: entry 0 is always the head.
    unique case ({accept, pop})
      2'b10: begin
        if (count_q == 2'd0) mem_d[0] = new_entry;
        else                 mem_d[1] = new_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        count_d  = count_q - 2'd1;
      end
      2'b11: begin
        // Accept is only possible below full, so a pop+push here means count was 1.
        mem_d[0] = new_entry;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      prev_q         <= '0;
      count_q        <= 2'd0;
      sample_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      count_q        <= count_d;
      sample_count_q <= sample_count_d;
    end
  end

  // NOTE: FIFO storage is not reset; outputs are gated by out_valid, so stale contents never escape.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sum_differencer.sv
// Directed, table-driven bench for sum_differencer: streaming vectors plus
// hand-written backpressure, reset and counter-wrap sequences.
module tb_sum_differencer;

  localparam int WIDTH = 16;

  logic clk;
  logic reset;

  sum_differencer_if #(.WIDTH(WIDTH)) bus ();

  sum_differencer #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] sum;
    logic        restart;
    logic [15:0] exp_out;
    logic        exp_first;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{16'd18,    1'b0, 16'd18,    1'b1, 1'b0};
    vecs[1] = '{16'd27,    1'b0, 16'd9,     1'b0, 1'b0};
    vecs[2] = '{16'd31,    1'b0, 16'd4,     1'b0, 1'b0};
    vecs[3] = '{16'hFFF0,  1'b0, 16'hFFD1,  1'b0, 1'b0};
    vecs[4] = '{16'h0010,  1'b0, 16'h0020,  1'b0, 1'b1};
    vecs[5] = '{16'd100,   1'b0, 16'd84,    1'b0, 1'b0};
    vecs[6] = '{16'd5,     1'b1, 16'd5,     1'b1, 1'b0};
    vecs[7] = '{16'd8,     1'b0, 16'd3,     1'b0, 1'b0};

    // Reset held with a valid sample offered: nothing may be accepted.
    reset          = 1'b0;
    bus.in_sum     = 16'd123;
    bus.in_valid   = 1'b1;
    bus.in_restart = 1'b0;
    bus.out_ready  = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out",       32'(bus.out),       32'd0);
    check("rst_out_first", 32'(bus.out_first), 32'd0);
    check("rst_out_wrap",  32'(bus.out_wrap),  32'd0);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rel_in_ready",     32'(bus.in_ready),     32'd1);
    check("rel_out_valid",    32'(bus.out_valid),    32'd0);
    check("rel_sample_count", 32'(bus.sample_count), 32'd0);

    // Streaming with out_ready=1: each edge pops the old head and pushes the new one.
    for (int i = 0; i < 8; i++) begin
      bus.in_sum     = vecs[i].sum;
      bus.in_restart = vecs[i].restart;
      bus.in_valid   = 1'b1;
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_out", i),       32'(bus.out),       32'(vecs[i].exp_out));
      check($sformatf("vec%0d_first", i),     32'(bus.out_first), 32'(vecs[i].exp_first));
      check($sformatf("vec%0d_wrap", i),      32'(bus.out_wrap),  32'(vecs[i].exp_wrap));
      check($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'd1);
      check($sformatf("vec%0d_count", i),     32'(bus.sample_count), 32'(i + 1));
    end

    // Drain, then a restart without valid must be ignored.
    bus.in_valid   = 1'b0;
    bus.in_restart = 1'b1;
    tick();
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_out_zero",  32'(bus.out),       32'd0);
    check("drain_first_zero", 32'(bus.out_first), 32'd0);
    bus.in_restart = 1'b0;
    bus.in_sum     = 16'd10;
    bus.in_valid   = 1'b1;
    tick();
    check("norestart_out",   32'(bus.out),       32'd2);
    check("norestart_first", 32'(bus.out_first), 32'd0);
    check("norestart_count", 32'(bus.sample_count), 32'd9);
    bus.in_valid = 1'b0;
    tick();

    // Backpressure from a fresh reset.
    reset = 1'b0;
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sum    = 16'd10;
    tick();
    check("bp_first_out",    32'(bus.out),       32'd10);
    check("bp_first_flag",   32'(bus.out_first), 32'd1);
    check("bp_ready_c1",     32'(bus.in_ready),  32'd1);
    bus.in_sum = 16'd20;
    tick();
    check("bp_full_ready",   32'(bus.in_ready),  32'd0);
    check("bp_hold_out",     32'(bus.out),       32'd10);
    bus.in_sum = 16'd30;
    tick();
    check("bp_still_full",   32'(bus.in_ready),  32'd0);
    check("bp_hold_out2",    32'(bus.out),       32'd10);
    check("bp_hold_first",   32'(bus.out_first), 32'd1);
    check("bp_count2",       32'(bus.sample_count), 32'd2);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pop1_out",     32'(bus.out),       32'd10);
    check("bp_pop1_first",   32'(bus.out_first), 32'd0);
    check("bp_pop1_ready",   32'(bus.in_ready),  32'd1);
    check("bp_no_accept_full", 32'(bus.sample_count), 32'd2);
    tick();
    check("bp_pop2_out",     32'(bus.out),       32'd10);
    check("bp_pop2_valid",   32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    check("bp_empty",        32'(bus.out_valid), 32'd0);
    check("bp_count3",       32'(bus.sample_count), 32'd3);

    // Mid-operation reset with two entries buffered.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sum    = 16'd50;
    tick();
    bus.in_sum = 16'd60;
    tick();
    check("mid_full", 32'(bus.in_ready), 32'd0);
    reset      = 1'b0;
    bus.in_sum = 16'd99;
    tick();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready),  32'd0);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rel_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rel_ready", 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sum    = 16'd7;
    tick();
    check("mid_out",   32'(bus.out),          32'd7);
    check("mid_first", 32'(bus.out_first),    32'd1);
    check("mid_count", 32'(bus.sample_count), 32'd1);

    // sample_count wraps from 0xFFFF to 0x0000.
    bus.in_sum = 16'd0;
    for (int i = 0; i < 65534; i++) tick();
    check("cnt_ffff", 32'(bus.sample_count), 32'h0000_FFFF);
    tick();
    check("cnt_wrap", 32'(bus.sample_count), 32'd0);
    bus.in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
